snax_alu_csr_ctrl: RTL and testbench

Parametrised control/status register block for the SNAX ALU accelerator.
- Latches configuration from the CSR manager and gates PE readiness through an explicit IDLE/BUSY state machine.
- Tracks the expected output count and exposes status, a cycle counter, an output counter and a completed-job counter as read-only CSRs.
- Adds explicit start semantics, config rejection while busy, illegal-opcode detection and a done pulse for the cluster interrupt path.

---
 rtl/snax_alu_csr_pkg.sv | 36 +++
 rtl/snax_alu_csr_counter.sv | 46 ++++
 rtl/snax_alu_csr_ctrl.sv | 159 +++++++++++++++
 tb/tb_snax_alu_csr_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snax_alu_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snax_alu_csr_pkg
// Purpose  : Shared register indices, bit positions and controller state type
//            for the SNAX ALU CSR controller.
// Revision : 1.0 - initial release
// ============================================================================
package snax_alu_csr_pkg;

    // Read/write CSR indices
    localparam int unsigned RW_OPCODE  = 0;
    localparam int unsigned RW_LENGTH  = 1;
    localparam int unsigned RW_CONTROL = 2;

    // Read-only CSR indices
    localparam int unsigned RO_STATUS  = 0;
    localparam int unsigned RO_PERF    = 1;
    localparam int unsigned RO_OUTPUTS = 2;
    localparam int unsigned RO_JOBS    = 3;

    // Control register bit positions
    localparam int unsigned CTRL_START = 0;

    // Status register bit positions
    localparam int unsigned STAT_BUSY  = 0;
    localparam int unsigned STAT_DONE  = 1;
    localparam int unsigned STAT_ERR   = 2;

    // Controller state
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/snax_alu_csr_counter.sv
`default_nettype none
// ============================================================================
// Module   : snax_alu_csr_counter
// Purpose  : Clearable up-counter with optional saturation at all-ones.
//            Clear has priority over enable.
// Revision : 1.0 - initial release
// ============================================================================
module snax_alu_csr_counter #(
    parameter int unsigned Width    = 32,
    parameter bit          Saturate = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d;
    logic [Width-1:0] count_q;

    // Next count: clear wins, otherwise increment unless pinned at all-ones
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            if (!(Saturate && (&count_q))) begin
                count_d = count_q + {{(Width-1){1'b0}}, 1'b1};
            end
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/snax_alu_csr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snax_alu_csr_ctrl
// Purpose  : CSR control/status block for the SNAX ALU accelerator. Latches
//            configuration, sequences IDLE/BUSY, counts outputs and cycles,
//            flags illegal opcodes and pulses done on job completion.
// Revision : 1.0 - initial release
// ============================================================================
module snax_alu_csr_ctrl
    import snax_alu_csr_pkg::*;
#(
    parameter int unsigned RegRWCount   = 3,
    parameter int unsigned RegROCount   = 4,
    parameter int unsigned RegDataWidth = 32,
    parameter int unsigned NumOps       = 4,
    parameter int unsigned OpWidth      = $clog2(NumOps)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [RegRWCount-1:0][RegDataWidth-1:0] csr_reg_set_i,
    input  logic                                    csr_reg_set_valid_i,
    output logic                                    csr_reg_set_ready_o,
    output logic [RegROCount-1:0][RegDataWidth-1:0] csr_reg_ro_set_o,
    input  logic                                    acc_output_success_i,
    output logic                                    acc_ready_o,
    output logic                                    acc_busy_o,
    output logic                                    acc_done_o,
    output logic [OpWidth-1:0]                      csr_alu_config_o
);

    ctrl_state_e                             state_q, state_d;
    logic [RegRWCount-1:0][RegDataWidth-1:0] rw_q, rw_d;
    logic                                    done_flag_q, done_flag_d;
    logic                                    err_q, err_d;
    logic                                    done_pulse_q, done_pulse_d;

    logic                    accept;
    logic                    start_req;
    logic                    op_legal;
    logic                    len_zero;
    logic                    start_go;
    logic                    complete;
    logic [RegDataWidth:0]   out_cnt_inc;
    logic [RegDataWidth-1:0] perf_cnt;
    logic [RegDataWidth-1:0] out_cnt;
    logic [RegDataWidth-1:0] job_cnt;

    assign accept    = csr_reg_set_valid_i && csr_reg_set_ready_o;
    assign start_req = csr_reg_set_i[RW_CONTROL][CTRL_START];
    // Legality uses the full register so that high garbage bits cannot alias a legal op
    assign op_legal  = csr_reg_set_i[RW_OPCODE] < RegDataWidth'(NumOps);
    assign len_zero  = (csr_reg_set_i[RW_LENGTH] == '0);
    assign start_go  = accept && start_req && op_legal;

    // One extra bit so that a length of all-ones can still be reached
    assign out_cnt_inc = {1'b0, out_cnt} + {{RegDataWidth{1'b0}}, 1'b1};
    assign complete    = (state_q == BUSY) && acc_output_success_i
                         && (out_cnt_inc == {1'b0, rw_q[RW_LENGTH]});

    // Next-state, shadow-register and status-flag logic
    always_comb begin
        state_d      = state_q;
        rw_d         = rw_q;
        done_flag_d  = done_flag_q;
        err_d        = err_q;
        done_pulse_d = 1'b0;
        if (accept) begin
            rw_d = csr_reg_set_i;
            if (op_legal) begin
                err_d = 1'b0;
            end
            if (start_req) begin
                if (!op_legal) begin
                    err_d = 1'b1;
                end else if (len_zero) begin
                    done_flag_d  = 1'b1;
                    done_pulse_d = 1'b1;
                end else begin
                    state_d     = BUSY;
                    done_flag_d = 1'b0;
                end
            end
        end
        if (complete) begin
            state_d      = IDLE;
            done_flag_d  = 1'b1;
            done_pulse_d = 1'b1;
        end
    end

    // Controller state and registered flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            rw_q         <= '0;
            done_flag_q  <= 1'b0;
            err_q        <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rw_q         <= rw_d;
            done_flag_q  <= done_flag_d;
            err_q        <= err_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    snax_alu_csr_counter #(
        .Width    (RegDataWidth),
        .Saturate (1'b1)
    ) i_perf_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (start_go),
        .en_i    (state_q == BUSY),
        .count_o (perf_cnt)
    );

    snax_alu_csr_counter #(
        .Width    (RegDataWidth),
        .Saturate (1'b0)
    ) i_out_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (start_go),
        .en_i    ((state_q == BUSY) && acc_output_success_i),
        .count_o (out_cnt)
    );

    snax_alu_csr_counter #(
        .Width    (RegDataWidth),
        .Saturate (1'b0)
    ) i_job_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (1'b0),
        .en_i    (complete || (start_go && len_zero)),
        .count_o (job_cnt)
    );

    assign csr_reg_set_ready_o = (state_q == IDLE);
    assign acc_ready_o         = (state_q == BUSY);
    assign acc_busy_o          = (state_q == BUSY);
    assign acc_done_o          = done_pulse_q;
    assign csr_alu_config_o    = rw_q[RW_OPCODE][OpWidth-1:0];

    // Read-only register view; unused indices read as zero
    always_comb begin
        csr_reg_ro_set_o                        = '0;
        csr_reg_ro_set_o[RO_STATUS][STAT_BUSY]  = (state_q == BUSY);
        csr_reg_ro_set_o[RO_STATUS][STAT_DONE]  = done_flag_q;
        csr_reg_ro_set_o[RO_STATUS][STAT_ERR]   = err_q;
        csr_reg_ro_set_o[RO_PERF]               = perf_cnt;
        csr_reg_ro_set_o[RO_OUTPUTS]            = out_cnt;
        csr_reg_ro_set_o[RO_JOBS]               = job_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_snax_alu_csr_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_snax_alu_csr_ctrl
// Purpose  : Scoreboard bench for snax_alu_csr_ctrl. Jobs are issued with
//            random parameters; expected completion snapshots are queued and
//            compared by a monitor whenever acc_done_o pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snax_alu_csr_ctrl;

    localparam int W    = 32;
    localparam int NOPS = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [2:0][W-1:0]   set_i = '0;
    logic                set_valid = 1'b0;
    logic                set_ready;
    logic [3:0][W-1:0]   ro;
    logic                success = 1'b0;
    logic                acc_ready;
    logic                busy;
    logic                done;
    logic [1:0]          cfg;

    always #5 clk = ~clk;

    snax_alu_csr_ctrl #(
        .RegRWCount   (3),
        .RegROCount   (4),
        .RegDataWidth (W),
        .NumOps       (NOPS)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .csr_reg_set_i        (set_i),
        .csr_reg_set_valid_i  (set_valid),
        .csr_reg_set_ready_o  (set_ready),
        .csr_reg_ro_set_o     (ro),
        .acc_output_success_i (success),
        .acc_ready_o          (acc_ready),
        .acc_busy_o           (busy),
        .acc_done_o           (done),
        .csr_alu_config_o     (cfg)
    );

    typedef struct {
        logic [W-1:0] status;
        logic [W-1:0] perf;
        logic [W-1:0] outs;
        logic [W-1:0] jobs;
        logic [1:0]   cfg;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Job-level reference state
    logic [W-1:0] m_perf, m_out, m_jobs;
    logic         m_done, m_err;
    logic [1:0]   m_cfg;

    function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    function automatic logic [W-1:0] m_status();
        return {{(W-3){1'b0}}, m_err, m_done, 1'b0};
    endfunction

    function automatic void reset_model();
        m_perf = '0; m_out = '0; m_jobs = '0;
        m_done = 1'b0; m_err = 1'b0; m_cfg = '0;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.status = m_status();
        e.perf   = m_perf;
        e.outs   = m_out;
        e.jobs   = m_jobs;
        e.cfg    = m_cfg;
        exp_q.push_back(e);
    endfunction

    // Present a write and hold it until the DUT accepts; applies register-write rules to the model
    task automatic write_csr(input logic [W-1:0] op, input logic [W-1:0] len, input logic start);
        int   waited = 0;
        logic acc;
        set_i[0]  = op;
        set_i[1]  = len;
        set_i[2]  = {{(W-1){1'b0}}, start};
        set_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc = set_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        set_valid = 1'b0;
        m_cfg = op[1:0];
        if (op < NOPS) m_err = 1'b0;
        if (start && !(op < NOPS)) m_err = 1'b1;
    endtask

    // Full job: start, random-spaced output pulses, expected snapshot queued
    task automatic run_job(input logic [W-1:0] op, input logic [W-1:0] len, input int gmin, input int gmax);
        int sum = 0;
        int gap;
        write_csr(op, len, 1'b1);
        if (!(op < NOPS)) begin
            @(negedge clk);
            check("illegal_status", ro[0], m_status());
            check("illegal_idle", busy, 0);
            repeat (2) @(posedge clk);
            #1;
            return;
        end
        for (int i = 0; i < int'(len); i++) begin
            gap = int'($urandom_range(gmax, gmin));
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            success = 1'b1;
            @(posedge clk);
            #1;
            success = 1'b0;
            sum += gap + 1;
        end
        m_perf = sum;
        m_out  = len;
        m_jobs = m_jobs + 1;
        m_done = 1'b1;
        push_exp();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued snapshot
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_status", ro[0], e.status);
                    check("done_perf",   ro[1], e.perf);
                    check("done_outs",   ro[2], e.outs);
                    check("done_jobs",   ro[3], e.jobs);
                    check("done_cfg",    cfg,   e.cfg);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [W-1:0] op, len;
        int r;
        reset_model();

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_set_ready", set_ready, 1);
        check("rst_acc_ready", acc_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg", cfg, 0);
        for (int i = 0; i < 4; i++) check($sformatf("rst_ro%0d", i), ro[i], 0);
        @(posedge clk);
        #1;

        // Reference job: op 2, length 4, pulses every second cycle; a write is held off meanwhile
        write_csr(2, 4, 1'b1);
        m_perf = 8; m_out = 4; m_jobs = m_jobs + 1; m_done = 1'b1;
        push_exp();
        @(negedge clk);
        check("busy_flag", busy, 1);
        check("busy_acc_ready", acc_ready, 1);
        check("busy_set_ready", set_ready, 0);
        check("busy_ro0", ro[0], 1);
        set_i[0] = 3; set_i[1] = 9; set_i[2] = '0;
        set_valid = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            success = 1'b1;
            @(posedge clk);
            #1;
            success = 1'b0;
            if (i < 3) begin
                @(negedge clk);
                check("bp_set_ready", set_ready, 0);
                check("bp_cfg", cfg, 2);
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        check("first_idle_ready", set_ready, 1);
        check("first_idle_done", done, 1);
        check("first_idle_cfg", cfg, 2);
        @(posedge clk);
        #1;
        set_valid = 1'b0;
        m_cfg = 2'd3;
        m_err = 1'b0;
        @(negedge clk);
        check("held_write_cfg", cfg, 3);
        check("held_write_ro0", ro[0], m_status());
        check("held_write_ro1", ro[1], m_perf);
        check("held_write_ro3", ro[3], m_jobs);
        check("held_write_done", done, 0);
        @(posedge clk);
        #1;

        // Zero-length start completes without a busy cycle
        write_csr(1, 0, 1'b1);
        m_perf = 0; m_out = 0; m_jobs = m_jobs + 1; m_done = 1'b1;
        push_exp();
        @(negedge clk);
        check("len0_no_busy", busy, 0);
        @(posedge clk);
        #1;

        // Illegal opcodes, including one whose low bits alias a legal op
        run_job(4, 3, 0, 1);
        run_job(32'h0000_0102, 2, 0, 1);
        run_job(3, 2, 0, 1);

        // Config-only write and ignored success pulses while idle
        write_csr(1, 7, 1'b0);
        @(negedge clk);
        check("cfgonly_cfg", cfg, 1);
        check("cfgonly_ro0", ro[0], m_status());
        check("cfgonly_ro1", ro[1], m_perf);
        check("cfgonly_ro2", ro[2], m_out);
        check("cfgonly_ro3", ro[3], m_jobs);
        success = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        success = 1'b0;
        @(negedge clk);
        check("idle_success_ro2", ro[2], m_out);
        check("idle_success_ro1", ro[1], m_perf);
        @(posedge clk);
        #1;

        // Randomised mix of jobs, config writes and illegal starts
        for (int k = 0; k < 30; k++) begin
            r = int'($urandom_range(9, 0));
            if (r == 0) begin
                op  = W'($urandom_range(NOPS - 1, 0));
                len = W'($urandom_range(9, 0));
                write_csr(op, len, 1'b0);
                @(negedge clk);
                check("rand_cfgonly_cfg", cfg, m_cfg);
                check("rand_cfgonly_ro0", ro[0], m_status());
                @(posedge clk);
                #1;
            end else if (r == 1) begin
                if ($urandom_range(1, 0) == 1) op = W'(NOPS + int'($urandom_range(3, 0)));
                else                           op = 32'h0000_0100 | W'($urandom_range(3, 0));
                run_job(op, W'($urandom_range(5, 1)), 0, 1);
            end else begin
                op  = W'($urandom_range(NOPS - 1, 0));
                len = W'($urandom_range(6, 0));
                run_job(op, len, 0, 2);
            end
        end

        // Asynchronous reset in the middle of a job
        write_csr(1, 5, 1'b1);
        repeat (2) begin
            success = 1'b1;
            @(posedge clk);
            #1;
            success = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        reset_model();
        check("arst_set_ready", set_ready, 1);
        check("arst_acc_ready", acc_ready, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_cfg", cfg, 0);
        for (int i = 0; i < 4; i++) check($sformatf("arst_ro%0d", i), ro[i], 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        run_job(3, 2, 0, 1);

        repeat (5) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
